// File: rtl/multicycle_sequencer_if.sv
// Control bus between the multicycle sequencer and the shared CPU datapath.
// master: the sequencer (takes IR fields, ALU flag and stall; drives every
//         datapath enable/select plus retire/halted/state status).
// slave : the datapath side (drives IR fields, zero and stall; takes controls).
interface multicycle_sequencer_if #(
    parameter int unsigned ALU_W = 3
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             stall;
    logic             IRWr;
    logic             AWr;
    logic             PCWr;
    logic [1:0]       PCSel;
    logic             MemWr;
    logic             RegWr;
    logic [1:0]       RegDst;
    logic [1:0]       MemToReg;
    logic             ALUSrc;
    logic [ALU_W-1:0] ALUcntrl;
    logic             retire;
    logic             halted;
    logic [2:0]       state;

    modport master (
        input  opcode, funct, zero, stall,
        output IRWr, AWr, PCWr, PCSel, MemWr, RegWr, RegDst, MemToReg,
               ALUSrc, ALUcntrl, retire, halted, state
    );

    modport slave (
        output opcode, funct, zero, stall,
        input  IRWr, AWr, PCWr, PCSel, MemWr, RegWr, RegDst, MemToReg,
               ALUSrc, ALUcntrl, retire, halted, state
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM: steps each instruction through FETCH, DECODE,
// EXECUTE, MEMORY and WRITEBACK and drives the datapath controls so that each
// shared resource is used in exactly one phase per instruction.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; aborts any instruction in flight
//   bus   - multicycle_sequencer_if.master (IR fields, zero, stall in;
//           enables, selects, retire, halted, state out)
// Controls are combinational from state, opcode, funct and zero.
module multicycle_sequencer #(
    parameter int unsigned ALU_W = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_sequencer_if.master bus
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_XORI = 6'h0e;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2a;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_XOR = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(3);

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    localparam logic [1:0] DST_RD = 2'd0;
    localparam logic [1:0] DST_RA = 2'd1;
    localparam logic [1:0] DST_RT = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    logic [2:0]       state_q;
    logic [2:0]       state_next;

    logic             is_add, is_sub, is_slt, is_jr, is_r_alu;
    logic             is_addi, is_xori, is_lw, is_sw;
    logic             is_beq, is_bne, is_j, is_jal, legal;
    logic             op_alu_src;
    logic [ALU_W-1:0] op_alu_cntrl;
    logic             br_taken;

    logic             ir_wr, a_wr, pc_wr, mem_wr, reg_wr, retire;
    logic [1:0]       pc_sel, reg_dst, mem_to_reg;
    logic             alu_src;
    logic [ALU_W-1:0] alu_cntrl;

    // Instruction class decode from the IR fields
    always_comb begin
        is_add   = (bus.opcode == OP_R) && (bus.funct == FN_ADD);
        is_sub   = (bus.opcode == OP_R) && (bus.funct == FN_SUB);
        is_slt   = (bus.opcode == OP_R) && (bus.funct == FN_SLT);
        is_jr    = (bus.opcode == OP_R) && (bus.funct == FN_JR);
        is_r_alu = is_add || is_sub || is_slt;
        is_addi  = (bus.opcode == OP_ADDI);
        is_xori  = (bus.opcode == OP_XORI);
        is_lw    = (bus.opcode == OP_LW);
        is_sw    = (bus.opcode == OP_SW);
        is_beq   = (bus.opcode == OP_BEQ);
        is_bne   = (bus.opcode == OP_BNE);
        is_j     = (bus.opcode == OP_J);
        is_jal   = (bus.opcode == OP_JAL);
        legal    = is_r_alu || is_jr || is_addi || is_xori || is_lw || is_sw ||
                   is_beq || is_bne || is_j || is_jal;

        op_alu_src = is_addi || is_xori || is_lw || is_sw;
        if (is_sub || is_beq || is_bne) begin
            op_alu_cntrl = ALU_SUB;
        end else if (is_slt) begin
            op_alu_cntrl = ALU_SLT;
        end else if (is_xori) begin
            op_alu_cntrl = ALU_XOR;
        end else begin
            op_alu_cntrl = ALU_ADD;
        end

        br_taken = (is_beq && bus.zero) || (is_bne && !bus.zero);
    end

    // Next state and control outputs
    always_comb begin
        state_next = state_q;
        ir_wr      = 1'b0;
        a_wr       = 1'b0;
        pc_wr      = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        retire     = 1'b0;
        pc_sel     = PC_SEQ;
        reg_dst    = DST_RD;
        mem_to_reg = WB_ALU;
        alu_src    = 1'b0;
        alu_cntrl  = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                ir_wr      = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                a_wr       = 1'b1;
                state_next = legal ? S_EXECUTE : S_HALT;
            end
            S_EXECUTE: begin
                alu_src   = op_alu_src;
                alu_cntrl = op_alu_cntrl;
                if (is_r_alu || is_addi || is_xori) begin
                    state_next = S_WRITEBACK;
                end else if (is_lw || is_sw) begin
                    state_next = S_MEMORY;
                end else if (is_beq || is_bne) begin
                    pc_wr      = 1'b1;
                    pc_sel     = br_taken ? PC_BRANCH : PC_SEQ;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (is_j || is_jal) begin
                    pc_wr      = 1'b1;
                    pc_sel     = PC_JUMP;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                    if (is_jal) begin
                        reg_wr     = 1'b1;
                        reg_dst    = DST_RA;
                        mem_to_reg = WB_PC4;
                    end
                end else if (is_jr) begin
                    pc_wr      = 1'b1;
                    pc_sel     = PC_REG;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEMORY: begin
                // ALU controls held so the effective address stays stable
                alu_src   = op_alu_src;
                alu_cntrl = op_alu_cntrl;
                if (is_sw) begin
                    mem_wr     = 1'b1;
                    pc_wr      = 1'b1;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                alu_src    = op_alu_src;
                alu_cntrl  = op_alu_cntrl;
                reg_wr     = 1'b1;
                pc_wr      = 1'b1;
                retire     = 1'b1;
                reg_dst    = is_r_alu ? DST_RD : DST_RT;
                mem_to_reg = is_lw ? WB_MEM : WB_ALU;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        // Stall freezes the phase; selects stay so the datapath keeps its view
        if (bus.stall && (state_q != S_HALT)) begin
            state_next = state_q;
            ir_wr      = 1'b0;
            a_wr       = 1'b0;
            pc_wr      = 1'b0;
            mem_wr     = 1'b0;
            reg_wr     = 1'b0;
            retire     = 1'b0;
        end

        if (reset) begin
            state_next = S_FETCH;
            ir_wr      = 1'b0;
            a_wr       = 1'b0;
            pc_wr      = 1'b0;
            mem_wr     = 1'b0;
            reg_wr     = 1'b0;
            retire     = 1'b0;
            pc_sel     = PC_SEQ;
            reg_dst    = DST_RD;
            mem_to_reg = WB_ALU;
            alu_src    = 1'b0;
            alu_cntrl  = ALU_ADD;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    assign bus.IRWr     = ir_wr;
    assign bus.AWr      = a_wr;
    assign bus.PCWr     = pc_wr;
    assign bus.PCSel    = pc_sel;
    assign bus.MemWr    = mem_wr;
    assign bus.RegWr    = reg_wr;
    assign bus.RegDst   = reg_dst;
    assign bus.MemToReg = mem_to_reg;
    assign bus.ALUSrc   = alu_src;
    assign bus.ALUcntrl = alu_cntrl;
    assign bus.retire   = retire;
    assign bus.halted   = (state_q == S_HALT);
    assign bus.state    = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench for multicycle_sequencer. The reference model
// describes each instruction class by its latency and by what happens on its
// first, second and final cycle.
module tb_multicycle_sequencer;

    localparam int unsigned ALU_W = 3;

    localparam int C_RALU = 0;
    localparam int C_IMM  = 1;
    localparam int C_LW   = 2;
    localparam int C_SW   = 3;
    localparam int C_BR   = 4;
    localparam int C_J    = 5;
    localparam int C_JAL  = 6;
    localparam int C_JR   = 7;
    localparam int C_ILL  = 8;

    localparam int HALT_CYCLES = 5;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_sequencer_if #(.ALU_W(ALU_W)) bus ();

    multicycle_sequencer #(.ALU_W(ALU_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [5:0] legal_op [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0e,
                                  6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h00};
    logic [5:0] legal_fn [13] = '{6'h20, 6'h22, 6'h2a, 6'h08, 6'h00, 6'h00,
                                  6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        int c;
        c = C_ILL;
        if (op == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2a) c = C_RALU;
            else if (fn == 6'h08) c = C_JR;
        end else if (op == 6'h08 || op == 6'h0e) c = C_IMM;
        else if (op == 6'h23) c = C_LW;
        else if (op == 6'h2b) c = C_SW;
        else if (op == 6'h04 || op == 6'h05) c = C_BR;
        else if (op == 6'h02) c = C_J;
        else if (op == 6'h03) c = C_JAL;
        return c;
    endfunction

    function automatic int latency(input int cls);
        if (cls == C_RALU || cls == C_IMM || cls == C_SW) return 4;
        if (cls == C_LW) return 5;
        if (cls == C_ILL) return 2 + HALT_CYCLES;
        return 3;
    endfunction

    // Phase name of cycle k: FETCH, DECODE, EXECUTE, then MEMORY for loads/stores
    function automatic int phase_of(input int cls, input int k);
        if (cls == C_ILL) return (k < 2) ? k : 5;
        if (k <= 2) return k;
        if (k == 3) return (cls == C_LW || cls == C_SW) ? 3 : 4;
        return 4;
    endfunction

    function automatic bit writes_reg(input int cls);
        return (cls == C_RALU || cls == C_IMM || cls == C_LW || cls == C_JAL);
    endfunction

    function automatic bit uses_alu(input int cls);
        return (cls == C_RALU || cls == C_IMM || cls == C_LW || cls == C_SW || cls == C_BR);
    endfunction

    function automatic int alu_cmd(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00 && fn == 6'h22) return 1;
        if (op == 6'h00 && fn == 6'h2a) return 3;
        if (op == 6'h0e) return 2;
        if (op == 6'h04 || op == 6'h05) return 1;
        return 0;
    endfunction

    function automatic int pc_sel_exp(input int cls, input logic [5:0] op, input logic z);
        if (cls == C_BR) return ((op == 6'h04 && z) || (op == 6'h05 && !z)) ? 1 : 0;
        if (cls == C_J || cls == C_JAL) return 2;
        if (cls == C_JR) return 3;
        return 0;
    endfunction

    function automatic int reg_dst_exp(input int cls);
        if (cls == C_RALU) return 0;
        if (cls == C_JAL) return 1;
        return 2;
    endfunction

    function automatic int mem_to_reg_exp(input int cls);
        if (cls == C_LW) return 1;
        if (cls == C_JAL) return 2;
        return 0;
    endfunction

    function automatic logic [31:0] enables_now();
        return 32'({bus.IRWr, bus.AWr, bus.PCWr, bus.MemWr, bus.RegWr, bus.retire});
    endfunction

    function automatic logic [31:0] selects_now();
        return 32'({bus.PCSel, bus.RegDst, bus.MemToReg, bus.ALUSrc, bus.ALUcntrl});
    endfunction

    // One reset cycle: every enable and select must be 0 while reset is high
    task automatic reset_cycle(input string tag);
        @(negedge clk);
        reset     = 1'b1;
        bus.stall = 1'($urandom_range(0, 1));
        bus.zero  = 1'($urandom_range(0, 1));
        #1;
        check({tag, "_rst_en"}, enables_now(), 32'd0);
        check({tag, "_rst_sel"}, selects_now(), 32'd0);
    endtask

    // Drives one instruction cycle by cycle and checks each cycle against the model.
    // zmode: 0/1 fixed zero flag, 2 random per cycle. force_k/force_len plant a
    // stall burst; abort_k >= 0 asserts reset in that cycle instead.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                             input bit rnd_stall, input int force_k, input int force_len,
                             input int abort_k);
        int  cls;
        int  n;
        int  stalls_left;
        bit  last;
        bit  stalled;
        logic [31:0] exp_en;
        cls = classify(op, fn);
        n   = latency(cls);
        for (int k = 0; k < n; k++) begin
            if (k == force_k) stalls_left = force_len;
            else if (rnd_stall && $urandom_range(0, 3) == 0) stalls_left = $urandom_range(1, 3);
            else stalls_left = 0;
            forever begin
                @(negedge clk);
                reset     = 1'b0;
                bus.opcode = (k == 0) ? 6'($urandom_range(0, 63)) : op;
                bus.funct  = (k == 0) ? 6'($urandom_range(0, 63)) : fn;
                bus.zero   = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode == 1);
                stalled    = (stalls_left > 0);
                bus.stall  = stalled;
                if (k == abort_k) begin
                    reset = 1'b1;
                    #1;
                    check("abort_state", 32'(bus.state), 32'(phase_of(cls, k)));
                    check("abort_en", enables_now(), 32'd0);
                    check("abort_sel", selects_now(), 32'd0);
                    return;
                end
                #1;
                last   = (k == n - 1) && (cls != C_ILL);
                exp_en = 32'({k == 0, k == 1, last, last && (cls == C_SW),
                              last && writes_reg(cls), last});
                if (stalled) exp_en = 32'd0;
                check("state", 32'(bus.state), 32'(phase_of(cls, k)));
                check("halted", 32'(bus.halted), 32'(cls == C_ILL && k >= 2));
                check("enables", enables_now(), exp_en);
                if (k >= 2 && uses_alu(cls)) begin
                    check("alusrc", 32'(bus.ALUSrc),
                          32'(cls == C_IMM || cls == C_LW || cls == C_SW));
                    check("alucntrl", 32'(bus.ALUcntrl), 32'(alu_cmd(op, fn)));
                end
                if (last) begin
                    check("pcsel", 32'(bus.PCSel), 32'(pc_sel_exp(cls, op, bus.zero)));
                    if (writes_reg(cls)) begin
                        check("regdst", 32'(bus.RegDst), 32'(reg_dst_exp(cls)));
                        check("memtoreg", 32'(bus.MemToReg), 32'(mem_to_reg_exp(cls)));
                    end
                end
                if (stalls_left == 0) break;
                stalls_left--;
            end
        end
        if (cls == C_ILL) reset_cycle("halt");
    endtask

    initial begin
        int idx;
        logic [5:0] op;
        logic [5:0] fn;
        reset      = 1'b1;
        bus.opcode = 6'h00;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;
        bus.stall  = 1'b0;

        reset_cycle("init0");
        reset_cycle("init1");

        // Directed instructions
        run_instr(6'h00, 6'h20, 0, 1'b0, -1, 0, -1);  // ADD
        run_instr(6'h23, 6'h11, 0, 1'b0, -1, 0, -1);  // LW
        run_instr(6'h2b, 6'h05, 0, 1'b0, -1, 0, -1);  // SW
        run_instr(6'h04, 6'h00, 1, 1'b0, -1, 0, -1);  // BEQ taken
        run_instr(6'h05, 6'h00, 1, 1'b0, -1, 0, -1);  // BNE not taken
        run_instr(6'h03, 6'h00, 0, 1'b0, -1, 0, -1);  // JAL
        run_instr(6'h00, 6'h08, 0, 1'b0, -1, 0, -1);  // JR
        run_instr(6'h23, 6'h00, 0, 1'b0, 3, 3, -1);   // LW, 3-cycle stall in MEMORY
        run_instr(6'h00, 6'h2a, 2, 1'b0, 0, 2, -1);   // SLT, stall in FETCH
        run_instr(6'h0e, 6'h00, 2, 1'b0, 3, 1, -1);   // XORI, stall in WRITEBACK

        // Illegal opcode, then reset from HALT
        run_instr(6'h3f, 6'h00, 2, 1'b1, -1, 0, -1);
        run_instr(6'h00, 6'h20, 0, 1'b0, -1, 0, -1);

        // Reset during WRITEBACK of an ADD
        run_instr(6'h00, 6'h20, 0, 1'b0, -1, 0, 3);
        run_instr(6'h08, 6'h00, 0, 1'b0, -1, 0, -1);

        // Random legal instructions with random stalls
        for (int i = 0; i < 250; i++) begin
            idx = $urandom_range(0, 12);
            op  = legal_op[idx];
            fn  = (op == 6'h00) ? legal_fn[idx] : 6'($urandom_range(0, 63));
            run_instr(op, fn, 2, 1'b1, -1, 0, -1);
        end

        // Random aborts
        for (int i = 0; i < 15; i++) begin
            idx = $urandom_range(0, 12);
            op  = legal_op[idx];
            fn  = (op == 6'h00) ? legal_fn[idx] : 6'($urandom_range(0, 63));
            run_instr(op, fn, 2, 1'b1, -1, 0,
                      $urandom_range(0, latency(classify(op, fn)) - 1));
        end

        // Random illegal encodings
        for (int i = 0; i < 6; i++) begin
            do begin
                op = (i % 2 == 0) ? 6'($urandom_range(0, 63)) : 6'h00;
                fn = 6'($urandom_range(0, 63));
            end while (classify(op, fn) != C_ILL);
            run_instr(op, fn, 2, 1'b1, -1, 0, -1);
        end

        run_instr(6'h2b, 6'h00, 2, 1'b1, -1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
